// File: rtl/cp0_pkg.sv
// Shared CP0 register numbers, exception codes and field positions.
package cp0_pkg;

   localparam logic [4:0] REG_COUNT   = 5'd9;
   localparam logic [4:0] REG_COMPARE = 5'd11;
   localparam logic [4:0] REG_STATUS  = 5'd12;
   localparam logic [4:0] REG_CAUSE   = 5'd13;
   localparam logic [4:0] REG_EPC     = 5'd14;
   localparam logic [4:0] REG_PRID    = 5'd15;

   localparam logic [4:0] EXC_INT = 5'h00;
   localparam logic [4:0] EXC_OV  = 5'h0C;

   localparam int ST_IE     = 0;
   localparam int ST_EXL    = 1;
   localparam int ST_IM_LO  = 8;
   localparam int CA_IP_LO  = 8;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances once every COUNT_DIV cycles and raises TI on a Compare match.
module cp0_timer #(
   parameter int COUNT_DIV = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti
);

   localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

   logic [PW-1:0] phase_q, phase_d;
   logic [31:0]   count_q, count_d;
   logic [31:0]   compare_q, compare_d;
   logic          ti_q, ti_d;
   logic          tick;

   assign tick = (phase_q == PW'(COUNT_DIV - 1));

   always_comb begin
      phase_d   = tick ? '0 : phase_q + PW'(1);
      count_d   = count_q;
      compare_d = compare_q;
      ti_d      = ti_q;
      if (count_we) begin
         count_d = wdata;
         phase_d = '0;
      end else if (tick) begin
         count_d = count_q + 32'd1;
         if (count_d == compare_q) ti_d = 1'b1;
      end
      // A Compare write acknowledges the timer even if a match lands on the same edge.
      if (compare_we) begin
         compare_d = wdata;
         ti_d      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q   <= '0;
         count_q   <= '0;
         compare_q <= '0;
         ti_q      <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         ti_q      <= ti_d;
      end
   end

   assign count   = count_q;
   assign compare = compare_q;
   assign ti      = ti_q;

endmodule

// File: rtl/cp0_exception.sv
// CP0 exception responder: Status/Cause/EPC state, interrupt/overflow entry, ERET return, MTC0/MFC0.
module cp0_exception
   import cp0_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
   parameter logic [31:0] PRID       = 32'h0001_8000,
   parameter int          COUNT_DIV  = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_E,
   input  logic [31:0] pc_E,
   input  logic        bd_E,
   input  logic        overflow_E,
   input  logic        eret_E,
   input  logic        mtc0_we,
   input  logic [4:0]  cp0_addr,
   input  logic [31:0] cp0_wdata,
   output logic [31:0] cp0_rdata,
   input  logic [5:0]  hw_int,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        exl_o,
   output logic [31:0] epc_o
);

   logic [7:0]  im_q, im_d;
   logic        exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
   logic [1:0]  ip_sw_q, ip_sw_d;
   logic [4:0]  exc_code_q, exc_code_d;
   logic [5:0]  hw_q, hw_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] count, compare;
   logic        ti;
   logic [7:0]  ip;
   logic        int_pend, exc, eret_take, wr;
   logic [31:0] status_r, cause_r;

   assign ip        = {hw_q[5] | ti, hw_q[4:0], ip_sw_q};
   assign int_pend  = (|(ip & im_q)) & ie_q & ~exl_q;
   assign exc       = valid_E & (int_pend | overflow_E);
   assign eret_take = valid_E & eret_E & ~exc;
   assign wr        = mtc0_we & valid_E & ~exc;

   // Gated with rst_n so the flush drops the moment reset asserts, whatever E holds.
   assign redirect    = rst_n & (exc | eret_take);
   assign redirect_pc = exc ? EXC_VECTOR : epc_q;

   cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .count_we   (wr && (cp0_addr == REG_COUNT)),
      .compare_we (wr && (cp0_addr == REG_COMPARE)),
      .wdata      (cp0_wdata),
      .count      (count),
      .compare    (compare),
      .ti         (ti)
   );

   always_comb begin
      im_d       = im_q;
      exl_d      = exl_q;
      ie_d       = ie_q;
      bd_d       = bd_q;
      ip_sw_d    = ip_sw_q;
      exc_code_d = exc_code_q;
      epc_d      = epc_q;
      hw_d       = hw_int;
      if (wr) begin
         case (cp0_addr)
            REG_STATUS: begin
               im_d  = cp0_wdata[ST_IM_LO +: 8];
               exl_d = cp0_wdata[ST_EXL];
               ie_d  = cp0_wdata[ST_IE];
            end
            REG_CAUSE: ip_sw_d = cp0_wdata[CA_IP_LO +: 2];
            REG_EPC:   epc_d   = cp0_wdata;
            default: ;
         endcase
      end
      // Nested exceptions keep the original return point.
      if (exc) begin
         if (!exl_q) begin
            epc_d = bd_E ? pc_E - 32'd4 : pc_E;
            bd_d  = bd_E;
         end
         exc_code_d = int_pend ? EXC_INT : EXC_OV;
         exl_d      = 1'b1;
      end else if (eret_take) begin
         exl_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         im_q       <= '0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         ip_sw_q    <= '0;
         exc_code_q <= '0;
         hw_q       <= '0;
         epc_q      <= '0;
      end else begin
         im_q       <= im_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         bd_q       <= bd_d;
         ip_sw_q    <= ip_sw_d;
         exc_code_q <= exc_code_d;
         hw_q       <= hw_d;
         epc_q      <= epc_d;
      end
   end

   assign status_r = {16'b0, im_q, 6'b0, exl_q, ie_q};
   assign cause_r  = {bd_q, ti, 14'b0, ip, 1'b0, exc_code_q, 2'b0};

   always_comb begin
      cp0_rdata = '0;
      case (cp0_addr)
         REG_COUNT:   cp0_rdata = count;
         REG_COMPARE: cp0_rdata = compare;
         REG_STATUS:  cp0_rdata = status_r;
         REG_CAUSE:   cp0_rdata = cause_r;
         REG_EPC:     cp0_rdata = epc_q;
         REG_PRID:    cp0_rdata = PRID;
         default:     cp0_rdata = '0;
      endcase
   end

   assign exl_o = exl_q;
   assign epc_o = epc_q;

endmodule

// File: tb/tb_cp0_exception.sv
// Bench for cp0_exception: directed vector table, timer/reset sequences, randomized run against a model.
module tb_cp0_exception;
   localparam logic [31:0] VEC    = 32'hBFC0_0380;
   localparam logic [31:0] PRID_V = 32'h0001_8000;
   localparam int          DIV    = 2;
   localparam logic        T = 1'b1;
   localparam logic        F = 1'b0;
   localparam logic [31:0] Z = 32'h0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_E, bd_E, overflow_E, eret_E, mtc0_we;
   logic [31:0] pc_E, cp0_wdata, cp0_rdata, redirect_pc, epc_o;
   logic [4:0]  cp0_addr;
   logic [5:0]  hw_int;
   logic        redirect, exl_o;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   cp0_exception #(.EXC_VECTOR(VEC), .PRID(PRID_V), .COUNT_DIV(DIV)) dut (
      .clk(clk), .rst_n(rst_n), .valid_E(valid_E), .pc_E(pc_E), .bd_E(bd_E),
      .overflow_E(overflow_E), .eret_E(eret_E), .mtc0_we(mtc0_we), .cp0_addr(cp0_addr),
      .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .hw_int(hw_int), .redirect(redirect),
      .redirect_pc(redirect_pc), .exl_o(exl_o), .epc_o(epc_o)
   );

   typedef struct {
      logic v; logic [31:0] pc; logic bd, ov, er, we; logic [4:0] a; logic [31:0] wd; logic [5:0] hw;
      logic x_red; logic [31:0] x_rpc; logic x_exl; logic [31:0] x_epc, x_rd;
   } vec_t;

   function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic bd, input logic ov,
                               input logic er, input logic we, input logic [4:0] a, input logic [31:0] wd,
                               input logic [5:0] hw, input logic xr, input logic [31:0] xrpc,
                               input logic xe, input logic [31:0] xepc, input logic [31:0] xrd);
      vec_t r;
      r.v = v; r.pc = pc; r.bd = bd; r.ov = ov; r.er = er; r.we = we; r.a = a; r.wd = wd; r.hw = hw;
      r.x_red = xr; r.x_rpc = xrpc; r.x_exl = xe; r.x_epc = xepc; r.x_rd = xrd;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic bd, input logic ov,
                        input logic er, input logic we, input logic [4:0] a, input logic [31:0] wd,
                        input logic [5:0] hw);
      valid_E = v; pc_E = pc; bd_E = bd; overflow_E = ov; eret_E = er; mtc0_we = we;
      cp0_addr = a; cp0_wdata = wd; hw_int = hw;
      #1;
   endtask

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      drive(F, Z, F, F, F, F, 5'd0, Z, 6'd0);
      step();
      rst_n = 1'b1;
   endtask

   // Reference model state
   logic [7:0]  m_im;
   logic        m_exl, m_ie, m_bd, m_ti;
   logic [1:0]  m_ipsw;
   logic [4:0]  m_code;
   logic [5:0]  m_hw;
   logic [31:0] m_epc, m_cmp, m_base;
   longint      m_n, m_t0;

   function automatic logic [31:0] cnt_at(input longint e);
      return m_base + 32'((e - m_t0) / DIV);
   endfunction

   vec_t tbl[$];
   logic [4:0] addrs [7] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};

   initial begin
      int found;
      do_reset();

      // ---------------- directed table ----------------
      tbl.push_back(mk(F, Z,            F, F, F, F, 5'd12, Z,            6'd0, F, Z,            F, Z,            32'h0));
      tbl.push_back(mk(T, 32'h00400010, F, T, F, F, 5'd13, Z,            6'd0, T, VEC,          F, Z,            32'h0));
      tbl.push_back(mk(F, Z,            F, F, F, F, 5'd13, Z,            6'd0, F, Z,            T, 32'h00400010, 32'h00000030));
      tbl.push_back(mk(T, Z,            F, F, F, T, 5'd12, Z,            6'd0, F, Z,            T, 32'h00400010, 32'h00000002));
      tbl.push_back(mk(T, 32'h00400024, T, T, F, F, 5'd14, Z,            6'd0, T, VEC,          F, 32'h00400010, 32'h00400010));
      tbl.push_back(mk(F, Z,            F, F, F, F, 5'd13, Z,            6'd0, F, Z,            T, 32'h00400020, 32'h80000030));
      tbl.push_back(mk(T, 32'h00400100, F, T, F, F, 5'd14, Z,            6'd0, T, VEC,          T, 32'h00400020, 32'h00400020));
      tbl.push_back(mk(T, Z,            F, F, T, F, 5'd13, Z,            6'd0, T, 32'h00400020, T, 32'h00400020, 32'h80000030));
      tbl.push_back(mk(F, Z,            F, F, F, F, 5'd12, Z,            6'd0, F, Z,            F, 32'h00400020, 32'h0));
      tbl.push_back(mk(T, Z,            F, F, F, T, 5'd12, 32'h401,      6'd0, F, Z,            F, 32'h00400020, 32'h0));
      tbl.push_back(mk(F, Z,            F, F, F, F, 5'd12, Z,            6'd1, F, Z,            F, 32'h00400020, 32'h401));
      tbl.push_back(mk(T, 32'h00400200, F, F, F, F, 5'd13, Z,            6'd1, T, VEC,          F, 32'h00400020, 32'h80000430));
      tbl.push_back(mk(F, Z,            F, F, F, F, 5'd13, Z,            6'd1, F, Z,            T, 32'h00400200, 32'h00000400));
      tbl.push_back(mk(T, Z,            F, F, T, F, 5'd12, Z,            6'd1, T, 32'h00400200, T, 32'h00400200, 32'h403));
      tbl.push_back(mk(F, Z,            F, F, F, F, 5'd12, Z,            6'd0, F, Z,            F, 32'h00400200, 32'h401));
      tbl.push_back(mk(T, Z,            F, F, F, T, 5'd12, 32'h400,      6'd0, F, Z,            F, 32'h00400200, 32'h401));
      tbl.push_back(mk(F, Z,            F, F, F, F, 5'd12, Z,            6'd1, F, Z,            F, 32'h00400200, 32'h400));
      tbl.push_back(mk(T, 32'h00400280, F, F, F, F, 5'd12, Z,            6'd1, F, Z,            F, 32'h00400200, 32'h400));
      tbl.push_back(mk(T, 32'h00400300, F, T, T, F, 5'd12, Z,            6'd0, T, VEC,          F, 32'h00400200, 32'h400));
      tbl.push_back(mk(F, Z,            F, F, F, F, 5'd12, Z,            6'd0, F, Z,            T, 32'h00400300, 32'h402));
      tbl.push_back(mk(T, 32'h00400400, F, T, F, T, 5'd14, 32'h12345678, 6'd0, T, VEC,          T, 32'h00400300, 32'h00400300));
      tbl.push_back(mk(F, Z,            F, F, F, F, 5'd14, Z,            6'd0, F, Z,            T, 32'h00400300, 32'h00400300));
      tbl.push_back(mk(F, Z,            F, F, F, F, 5'd15, Z,            6'd0, F, Z,            T, 32'h00400300, PRID_V));
      tbl.push_back(mk(F, Z,            F, F, F, F, 5'd3,  Z,            6'd0, F, Z,            T, 32'h00400300, 32'h0));

      foreach (tbl[i]) begin
         drive(tbl[i].v, tbl[i].pc, tbl[i].bd, tbl[i].ov, tbl[i].er, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].hw);
         chk($sformatf("vec%0d_redirect", i), 32'(redirect), 32'(tbl[i].x_red));
         if (tbl[i].x_red) chk($sformatf("vec%0d_redirect_pc", i), redirect_pc, tbl[i].x_rpc);
         chk($sformatf("vec%0d_exl", i), 32'(exl_o), 32'(tbl[i].x_exl));
         chk($sformatf("vec%0d_epc", i), epc_o, tbl[i].x_epc);
         chk($sformatf("vec%0d_rdata", i), cp0_rdata, tbl[i].x_rd);
         step();
      end

      // ---------------- timer interrupt ----------------
      do_reset();
      drive(T, Z, F, F, F, T, 5'd11, 32'd5,    6'd0); step();
      drive(T, Z, F, F, F, T, 5'd12, 32'h8001, 6'd0); step();
      drive(T, Z, F, F, F, T, 5'd9,  Z,        6'd0); step();
      found = -1;
      for (int k = 0; k < 30; k++) begin
         drive(T, 32'h00400500, F, F, F, F, 5'd13, Z, 6'd0);
         if (redirect) begin
            found = k;
            chk("timer_ti_at_irq", 32'(cp0_rdata[30]), 32'd1);
            chk("timer_irq_rpc", redirect_pc, VEC);
            step();
            break;
         end
         step();
      end
      n_cmp++;
      if (!(found inside {10, 11})) begin
         n_bad++;
         $display("FAIL timer_latency: got %0d cycles expected 10..11", found);
      end
      drive(F, Z, F, F, F, F, 5'd13, Z, 6'd0);
      chk("timer_exl", 32'(exl_o), 32'd1);
      chk("timer_exccode", 32'(cp0_rdata[6:2]), 32'd0);
      chk("timer_ti_held", 32'(cp0_rdata[30]), 32'd1);
      chk("timer_epc", epc_o, 32'h00400500);
      step();
      drive(T, Z, F, F, F, T, 5'd11, 32'd20, 6'd0);
      chk("timer_compare_prewrite", cp0_rdata, 32'd5);
      step();
      drive(F, Z, F, F, F, F, 5'd13, Z, 6'd0);
      chk("timer_ti_cleared", 32'(cp0_rdata[30]), 32'd0);

      // ---------------- async reset mid-operation ----------------
      drive(T, Z, F, T, F, F, 5'd14, Z, 6'd0);
      chk("areset_pre_redirect", 32'(redirect), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("areset_redirect", 32'(redirect), 32'd0);
      chk("areset_exl", 32'(exl_o), 32'd0);
      chk("areset_epc", epc_o, 32'd0);
      chk("areset_rd_epc", cp0_rdata, 32'd0);
      cp0_addr = 5'd11; #0.1;
      chk("areset_compare", cp0_rdata, 32'd0);
      step();

      // ---------------- randomized run against the model ----------------
      do_reset();
      m_im = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_ipsw = '0; m_code = '0; m_hw = '0;
      m_epc = '0; m_cmp = '0; m_base = '0; m_n = 0; m_t0 = 0;
      for (int it = 0; it < 600; it++) begin
         logic v, bd, ov, er, we, ip_on, xexc, xer, wr, ld;
         logic [4:0] a;
         logic [31:0] pc, wd, xrd, oldc, newc, tmp;
         logic [5:0] hw;
         logic [7:0] ip;
         int op;
         op = $urandom_range(0, 9);
         v = 1; ov = 0; er = 0; we = 0;
         a = addrs[$urandom_range(0, 6)];
         wd = $urandom;
         bd = 1'($urandom_range(0, 1));
         tmp = $urandom; pc = tmp & ~32'h3;
         hw = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'd0;
         case (op)
            3: ov = 1;
            4: er = 1;
            5, 6, 7: begin
               we = 1;
               if (a == 5'd11) wd = cnt_at(m_n) + 32'($urandom_range(0, 6));
               else if (a == 5'd9) wd = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
            end
            8, 9: begin
               v = 0; ov = 1'($urandom_range(0, 1)); er = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
            end
            default: ;
         endcase
         drive(v, pc, bd, ov, er, we, a, wd, hw);

         ip = {m_hw[5] | m_ti, m_hw[4:0], m_ipsw};
         ip_on = (|(ip & m_im)) && m_ie && !m_exl;
         xexc = v && (ip_on || ov);
         xer = v && er && !xexc;
         case (a)
            5'd9:  xrd = cnt_at(m_n);
            5'd11: xrd = m_cmp;
            5'd12: xrd = {16'b0, m_im, 6'b0, m_exl, m_ie};
            5'd13: xrd = {m_bd, m_ti, 14'b0, ip, 1'b0, m_code, 2'b0};
            5'd14: xrd = m_epc;
            5'd15: xrd = PRID_V;
            default: xrd = 32'h0;
         endcase
         chk($sformatf("rnd%0d_redirect", it), 32'(redirect), 32'(xexc || xer));
         if (xexc || xer) chk($sformatf("rnd%0d_redirect_pc", it), redirect_pc, xexc ? VEC : m_epc);
         chk($sformatf("rnd%0d_exl", it), 32'(exl_o), 32'(m_exl));
         chk($sformatf("rnd%0d_epc", it), epc_o, m_epc);
         chk($sformatf("rnd%0d_rdata_a%0d", it, a), cp0_rdata, xrd);
         step();

         oldc = cnt_at(m_n);
         m_n++;
         wr = we && v && !xexc;
         ld = wr && (a == 5'd9);
         if (ld) begin m_base = wd; m_t0 = m_n; end
         newc = cnt_at(m_n);
         if (wr && a == 5'd11) begin m_cmp = wd; m_ti = 0; end
         else if (!ld && newc != oldc && newc == m_cmp) m_ti = 1;
         if (wr && a == 5'd12) begin m_im = wd[15:8]; m_exl = wd[1]; m_ie = wd[0]; end
         if (wr && a == 5'd13) m_ipsw = wd[9:8];
         if (wr && a == 5'd14) m_epc = wd;
         if (xexc) begin
            if (!m_exl) begin m_epc = bd ? pc - 32'd4 : pc; m_bd = bd; end
            m_code = ip_on ? 5'h00 : 5'h0C;
            m_exl = 1;
         end else if (xer) begin
            m_exl = 0;
         end
         m_hw = hw;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
